// File: rtl/sn_pkg.sv
// Shared sizing and FSM state type for the sorting-network thermometer blocks.
package sn_pkg;
    localparam int TH_W  = 4;
    localparam int CNT_W = 4;

    typedef enum logic {IDLE, EMIT} state_t;
endpackage

// File: rtl/sn_thermo_lut.sv
// Beat value j -> sorted ones-first thermometer (top bit fills first).
module sn_thermo_lut #(
    parameter int TH_W = 4
) (
    input  logic [2:0]      j,
    output logic [TH_W-1:0] thermo
);
    always_comb begin
        thermo = '0;
        for (int i = 0; i < TH_W; i++)
            if (i < int'(j)) thermo[TH_W-1-i] = 1'b1;
    end
endmodule

// File: rtl/thermo_expander.sv
// Expands a binary population count into a stream of sorted TH_W-bit thermometer
// beats (inverse of the sorting-network counter), with valid/ready on both sides.
module thermo_expander
    import sn_pkg::*;
#(
    parameter int TH_W  = sn_pkg::TH_W,
    parameter int CNT_W = sn_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [TH_W-1:0]  out_thermo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [1:0]       out_idx
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(TH_W);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rem, rem_src;
    logic [2:0]       j;
    logic [TH_W-1:0]  beat;
    logic             accept, hs, hs_last;

    assign hs       = out_valid && out_ready;
    assign hs_last  = hs && out_last;
    assign in_ready = rst_n && ((state == IDLE) || hs_last);
    assign accept   = in_valid && in_ready;

    // One LUT serves both the first beat of a new count and each following beat.
    assign rem_src = accept ? in_count : rem - FULL;
    assign j       = (rem_src > FULL) ? 3'(TH_W) : rem_src[2:0];

    sn_thermo_lut #(.TH_W(TH_W)) u_lut (
        .j      (j),
        .thermo (beat)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = EMIT;
            EMIT: if (hs_last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem        <= '0;
            out_valid  <= 1'b0;
            out_thermo <= '0;
            out_last   <= 1'b0;
            out_idx    <= 2'd0;
        end else if (accept || (hs && !out_last)) begin
            rem        <= rem_src;
            out_valid  <= 1'b1;
            out_thermo <= beat;
            out_last   <= (rem_src <= FULL);
            out_idx    <= accept ? 2'd0 : out_idx + 2'd1;
        end else if (hs_last) begin
            out_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_thermo_expander.sv
// Scoreboard bench: accepted counts are expanded into expected beats by a
// plain-arithmetic model; a negedge monitor pops and compares each handshake.
module tb_thermo_expander;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_count;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_thermo;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic [1:0] out_idx;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_mode = 0;
    int q[$];
    int acc_cyc_prev = 0, acc_cyc_last = 0;
    bit acc_prev = 0, stall_prev = 0;
    int stall_val = 0;

    thermo_expander dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_count   (in_count),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_thermo (out_thermo),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_idx    (out_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Beat encoding: {thermo[3:0], last, idx[1:0]}
    function automatic int pack(input int th, input int last, input int idx);
        return (th << 3) | (last << 2) | idx;
    endfunction

    function automatic int cur_beat();
        return pack(int'(out_thermo), int'(out_last), int'(out_idx));
    endfunction

    task automatic push_expected(input int k);
        int n, ones;
        n = (k == 0) ? 1 : (k + 3) / 4;
        for (int b = 0; b < n; b++) begin
            ones = (b < n - 1) ? 4 : k - 4 * (n - 1);
            q.push_back(pack((15 << (4 - ones)) & 15, (b == n - 1) ? 1 : 0, b));
        end
    endtask

    // out_ready driver: 0 = always high, 1 = toggle 1010..., 2 = random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            acc_prev   = 0;
            stall_prev = 0;
        end else begin
            chk("in_ready", int'(in_ready),
                int'((q.size() == 0) || (q.size() == 1 && out_ready)));
            chk("out_valid", int'(out_valid), int'(q.size() != 0));
            if (acc_prev) begin
                chk("latency_valid", int'(out_valid), 1);
                chk("latency_idx", int'(out_idx), 0);
            end
            if (stall_prev) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_hold", cur_beat(), stall_val);
            end
            if (out_valid && out_ready && q.size() != 0) begin
                chk("beat", cur_beat(), q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = cur_beat();
            acc_prev   = in_valid && in_ready;
            if (in_valid && in_ready) begin
                push_expected(int'(in_count));
                acc_cyc_prev = acc_cyc_last;
                acc_cyc_last = cyc;
            end
        end
    end

    task automatic send(input int k);
        bit ok;
        in_count = 4'(k);
        in_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        bit ok;
        in_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_thermo", int'(out_thermo), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single-beat, multi-beat and zero counts
        send(3);  drain();
        send(9);  drain();
        send(0);  drain();

        // Back-to-back counts: second accept must land on the very next edge
        send(4);
        send(6);
        drain();
        chk("b2b_accept_gap", acc_cyc_last - acc_cyc_prev, 1);

        // Stalled stream with out_ready toggling
        ready_mode = 1;
        send(15);
        drain();
        ready_mode = 0;
        idle(2);

        // Reset in the middle of a count
        send(12);
        in_valid = 1'b0;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid && out_idx == 2'd1) begin
                ok = 1;
                break;
            end
        end
        chk("mid_rst_reach_beat1", int'(ok), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_release_in_ready", int'(in_ready), 1);
        idle(4);

        // Randomized counts, gaps and backpressure
        ready_mode = 2;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send(int'($urandom_range(0, 15)));
        end
        ready_mode = 0;
        drain();
        chk("final_queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
